cg_vector_pingpong_mem: RTL and testbench

Double-banked vector store for the conjugate-gradient datapath. It holds one full residual/direction vector of `no_of_units`-wide rows in each bank. The solver reads the "previous" vector (rKold) from one bank while writing the "new" vector into the other, and a `swap` pulse exchanges the roles at an iteration boundary. The block adds a registered read port, an out-of-range guard, and a hardware clear sequencer that zeroes the write bank before an iteration.

---
 rtl/cg_vector_pingpong_mem.sv | 149 ++++++++++++++
 tb/tb_cg_vector_pingpong_mem.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cg_vector_pingpong_mem.sv
// Double-banked row store: read one bank, write the other, swap at iteration boundaries.
// Optional `CG_VBUF_COMB_READ_EN selects the legacy combinational read port.
module cg_vector_pingpong_mem #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int depth         = 1024,
  parameter int address_width = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   write_enable,
  input  logic [address_width-1:0]               write_address,
  input  logic [element_width*no_of_units-1:0]   input_data,
  input  logic                                   read_enable,
  input  logic [address_width-1:0]               read_address,
  input  logic                                   swap,
  input  logic                                   clear,
  output logic [element_width*no_of_units-1:0]   memory_output,
  output logic                                   output_valid,
  output logic                                   active_bank,
  output logic                                   busy,
  output logic                                   clear_done,
  output logic                                   state_dbg
);

  localparam int W     = element_width * no_of_units;
  localparam int IDX_W = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [address_width:0]   DEPTH_L = (address_width+1)'(depth);
  localparam logic [address_width-1:0] LAST    = address_width'(depth - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] ptr_q, ptr_d;
  logic                     active_q, active_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [W-1:0] bank0_mem [depth];
  logic [W-1:0] bank1_mem [depth];

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [W-1:0]     mem_data;

  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic [W-1:0]     rd_row, rd_data;

  assign wr_in_range = ({1'b0, write_address} < DEPTH_L);
  assign rd_in_range = ({1'b0, read_address} < DEPTH_L);
  assign rd_idx      = read_address[IDX_W-1:0];
  assign rd_row      = active_q ? bank1_mem[rd_idx] : bank0_mem[rd_idx];
  assign rd_data     = rd_in_range ? rd_row : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    mem_idx  = write_address[IDX_W-1:0];
    mem_data = input_data;
    case (state_q)
      S_IDLE: begin
        mem_we = write_enable && wr_in_range;
        if (swap) active_d = ~active_q;
        if (clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        // Sweep owns the write port; external writes, swaps and clears are dropped.
        mem_we   = 1'b1;
        mem_idx  = ptr_q[IDX_W-1:0];
        mem_data = '0;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + address_width'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Write bank is the complement of the pre-swap read bank.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (active_q) bank0_mem[mem_idx] <= mem_data;
      else          bank1_mem[mem_idx] <= mem_data;
    end
  end

`ifdef CG_VBUF_COMB_READ_EN
  assign memory_output = rd_data;
  assign output_valid  = 1'b1;
`else
  logic [W-1:0] out_q, out_d;
  logic         valid_q, valid_d;

  always_comb begin
    out_d   = out_q;
    valid_d = read_enable;
    if (read_enable) out_d = rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign memory_output = out_q;
  assign output_valid  = valid_q;
`endif

  assign active_bank = active_q;
  assign busy        = busy_q;
  assign clear_done  = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cg_vector_pingpong_mem.sv
// Bench for cg_vector_pingpong_mem: bank-level reference model checked every cycle plus directed literals.
module tb_cg_vector_pingpong_mem;

  localparam int EW = 32;
  localparam int NU = 2;
  localparam int D  = 16;
  localparam int AW = 5;
  localparam int W  = EW * NU;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_enable = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [W-1:0]  input_data = '0;
  logic          read_enable = 1'b0;
  logic [AW-1:0] read_address = '0;
  logic          swap = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  memory_output;
  logic          output_valid, active_bank, busy, clear_done, state_dbg;

  cg_vector_pingpong_mem #(
    .element_width(EW), .no_of_units(NU), .depth(D), .address_width(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .write_address(write_address), .input_data(input_data),
    .read_enable(read_enable), .read_address(read_address),
    .swap(swap), .clear(clear),
    .memory_output(memory_output), .output_valid(output_valid),
    .active_bank(active_bank), .busy(busy), .clear_done(clear_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two banks of rows, a read-bank index, and a count of sweep rows left.
  logic [W-1:0] m_bank [2][D];
  bit           m_known [2][D];
  int           m_active = 0;
  int           m_clear_left = 0;
  logic [W-1:0] m_out = '0;
  bit           m_out_known = 1'b1;
  bit           m_valid = 1'b0;
  bit           m_done = 1'b0;
  int           m_rb, m_wb, m_row;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_clear_left = 0; m_out = '0; m_out_known = 1'b1;
      m_valid = 1'b0; m_done = 1'b0;
    end else begin
      m_rb = m_active;
      m_wb = 1 - m_active;
      if (read_enable) begin
        if (read_address < D) begin
          m_out       = m_bank[m_rb][read_address];
          m_out_known = m_known[m_rb][read_address];
        end else begin
          m_out = '0; m_out_known = 1'b1;
        end
      end
      m_valid = read_enable;
      m_done  = 1'b0;
      if (m_clear_left == 0) begin
        if (write_enable && write_address < D) begin
          m_bank[m_wb][write_address]  = input_data;
          m_known[m_wb][write_address] = 1'b1;
        end
        if (swap) m_active = 1 - m_active;
        if (clear) m_clear_left = D;
      end else begin
        m_row = D - m_clear_left;
        m_bank[m_wb][m_row]  = '0;
        m_known[m_wb][m_row] = 1'b1;
        m_clear_left--;
        if (m_clear_left == 0) m_done = 1'b1;
      end
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("active_bank", W'(active_bank), W'(m_active));
      check("busy", W'(busy), W'(m_clear_left != 0));
      check("clear_done", W'(clear_done), W'(m_done));
      check("output_valid", W'(output_valid), W'(m_valid));
      if (m_out_known) check("memory_output", memory_output, m_out);
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    write_enable = 1'b1; write_address = AW'(a); input_data = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input int a);
    read_enable = 1'b1; read_address = AW'(a);
    tick();
    read_enable = 1'b0;
  endtask

  task automatic sw();
    swap = 1'b1; tick(); swap = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  function automatic logic [W-1:0] pat(input int r);
    return {32'(r + 1) * 32'h0101_0101, 32'hC0DE_0000 | 32'(r)};
  endfunction

  int n_busy, n_done;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_memory_output", memory_output, '0);
    check("rst_output_valid", W'(output_valid), '0);
    check("rst_active_bank", W'(active_bank), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_clear_done", W'(clear_done), '0);
    reset = 1'b0;
    tick();
    rd(0);
    check("first_read_valid", W'(output_valid), W'(1));

    // write, swap, read back
    wr(3, 64'hA5A5_A5A5_A5A5_A5A5);
    wr(4, 64'h1111_1111_1111_1111);
    sw();
    check("swap_active", W'(active_bank), W'(1));
    rd(3);
    check("rd3", memory_output, 64'hA5A5_A5A5_A5A5_A5A5);
    check("rd3_valid", W'(output_valid), W'(1));
    rd(4);
    check("rd4", memory_output, 64'h1111_1111_1111_1111);

    // swap and write on the same edge: write uses the pre-swap bank (bank 1)
    sw();
    check("back_to_bank0", W'(active_bank), W'(0));
    swap = 1'b1; write_enable = 1'b1; write_address = 5'd2; input_data = 64'h7777_7777_7777_7777;
    tick();
    swap = 1'b0; write_enable = 1'b0;
    check("swap_write_active", W'(active_bank), W'(1));
    rd(2);
    check("swap_write_row2", memory_output, 64'h7777_7777_7777_7777);

    // clear sweep of bank 0 with write/swap attempts in flight
    for (int r = 0; r < D; r++) wr(r, pat(r));
    clr();
    n_busy = 0; n_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) n_busy++;
      if (clear_done) n_done++;
      write_enable = (c == 2); write_address = 5'd5; input_data = 64'hDEAD_BEEF_DEAD_BEEF;
      swap = (c == 3);
      tick();
    end
    write_enable = 1'b0; swap = 1'b0;
    check("busy_cycles", W'(n_busy), W'(D));
    check("done_pulses", W'(n_done), W'(1));
    check("swap_ignored", W'(active_bank), W'(1));
    sw();
    for (int r = 0; r < D; r++) begin
      rd(r);
      check("cleared_row", memory_output, '0);
    end

    // out-of-range read and write
    rd(20);
    check("oor_read", memory_output, '0);
    check("oor_read_valid", W'(output_valid), W'(1));
    wr(20, 64'hBAD0_BAD0_BAD0_BAD0);
    sw();
    rd(4);
    check("oor_write_no_alias", memory_output, 64'h1111_1111_1111_1111);
    rd(2);
    check("row2_bank1", memory_output, 64'h7777_7777_7777_7777);

    // reset during a clear of bank 0
    for (int r = 0; r < D; r++) wr(r, ~pat(r));
    clr();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_done", W'(clear_done), '0);
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int r = 0; r < D; r++) begin
      rd(r);
      if (r < 4) check("partial_zero", memory_output, '0);
      else if (r > 4) check("partial_kept", memory_output, ~pat(r));
    end
    check("partial_active", W'(active_bank), '0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
